// File: rtl/nnrv_exec_if.sv
// Decode-side and memory-side signal bundle of the nnrv execute stage.
// The slave modport is the execute stage; the master modport is its environment.
interface nnrv_exec_if #(
   parameter int XLEN = 32
);
   logic            i_id_valid;
   logic            o_id_stall;
   logic [2:0]      i_id_op;
   logic [2:0]      i_id_funct3;
   logic            i_id_funct7_5;
   logic [XLEN-1:0] i_id_pc;
   logic [XLEN-1:0] i_id_rs1_reg;
   logic [XLEN-1:0] i_id_rs2_reg;
   logic [XLEN-1:0] i_id_imm;
   logic            i_id_rd_en;
   logic [4:0]      i_id_rd;
   logic            o_id_rd_en;
   logic [4:0]      o_id_rd;
   logic [XLEN-1:0] o_id_rd_reg;
   logic            o_id_rd_ready;
   logic            o_mem_rd_en;
   logic [4:0]      o_mem_rd;
   logic [XLEN-1:0] o_mem_rd_reg;
   logic            o_mem_ram_rd_en;
   logic            o_mem_ram_wr_en;
   logic [XLEN-1:0] o_mem_ram_addr;
   logic [XLEN-1:0] o_mem_ram_data;
   logic [3:0]      o_mem_ram_mask;
   logic            o_mem_sign;
   logic            o_misalign;

   modport slave (
      input  i_id_valid, i_id_op, i_id_funct3, i_id_funct7_5, i_id_pc,
             i_id_rs1_reg, i_id_rs2_reg, i_id_imm, i_id_rd_en, i_id_rd,
      output o_id_stall, o_id_rd_en, o_id_rd, o_id_rd_reg, o_id_rd_ready,
             o_mem_rd_en, o_mem_rd, o_mem_rd_reg, o_mem_ram_rd_en, o_mem_ram_wr_en,
             o_mem_ram_addr, o_mem_ram_data, o_mem_ram_mask, o_mem_sign, o_misalign
   );

   modport master (
      output i_id_valid, i_id_op, i_id_funct3, i_id_funct7_5, i_id_pc,
             i_id_rs1_reg, i_id_rs2_reg, i_id_imm, i_id_rd_en, i_id_rd,
      input  o_id_stall, o_id_rd_en, o_id_rd, o_id_rd_reg, o_id_rd_ready,
             o_mem_rd_en, o_mem_rd, o_mem_rd_reg, o_mem_ram_rd_en, o_mem_ram_wr_en,
             o_mem_ram_addr, o_mem_ram_data, o_mem_ram_mask, o_mem_sign, o_misalign
   );
endinterface

// File: rtl/nnrv_exec.sv
// Execute stage of the nnrv RV32I(M) pipeline: ALU, load/store address generation and,
// when NNRV_MDU_EN is defined, single-cycle multiply plus a 32-cycle restoring divider.
module nnrv_exec #(
   parameter int XLEN = 32
) (
   input logic        i_clk,
   input logic        i_rst_n,
   nnrv_exec_if.slave bus
);

   localparam logic [2:0] OP_ALU_R  = 3'd1;
   localparam logic [2:0] OP_ALU_I  = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_STORE  = 3'd4;
   localparam logic [2:0] OP_LUI    = 3'd5;
   localparam logic [2:0] OP_AUIPC  = 3'd6;
   localparam logic [2:0] OP_MULDIV = 3'd7;

   logic            issue;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] ea;
   logic [XLEN-1:0] st_data;
   logic [3:0]      acc_mask;
   logic            acc_misalign;

   logic            mem_rd_en_reg, mem_rd_en_next;
   logic [4:0]      mem_rd_reg, mem_rd_next;
   logic [XLEN-1:0] rd_val_reg, rd_val_next;
   logic            ram_rd_en_reg, ram_rd_en_next;
   logic            ram_wr_en_reg, ram_wr_en_next;
   logic [XLEN-1:0] ram_addr_reg, ram_addr_next;
   logic [XLEN-1:0] ram_data_reg, ram_data_next;
   logic [3:0]      ram_mask_reg, ram_mask_next;
   logic            sign_reg, sign_next;
   logic            misalign_reg, misalign_next;
   logic            rd_ready_reg, rd_ready_next;

   // ------------------------------------------------------------------ ALU
   assign op_b = (bus.i_id_op == OP_ALU_R) ? bus.i_id_rs2_reg : bus.i_id_imm;

   always_comb begin
      alu_res = '0;
      case (bus.i_id_funct3)
         3'd0: alu_res = (bus.i_id_op == OP_ALU_R && bus.i_id_funct7_5) ?
                         bus.i_id_rs1_reg - op_b : bus.i_id_rs1_reg + op_b;
         3'd1: alu_res = bus.i_id_rs1_reg << op_b[4:0];
         3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.i_id_rs1_reg) < $signed(op_b))};
         3'd3: alu_res = {{(XLEN-1){1'b0}}, (bus.i_id_rs1_reg < op_b)};
         3'd4: alu_res = bus.i_id_rs1_reg ^ op_b;
         3'd5: alu_res = bus.i_id_funct7_5 ?
                         $unsigned($signed(bus.i_id_rs1_reg) >>> op_b[4:0]) :
                         bus.i_id_rs1_reg >> op_b[4:0];
         3'd6: alu_res = bus.i_id_rs1_reg | op_b;
         default: alu_res = bus.i_id_rs1_reg & op_b;
      endcase
   end

   // ------------------------------------------------------------------ load/store lanes
   assign ea      = bus.i_id_rs1_reg + bus.i_id_imm;
   assign st_data = bus.i_id_rs2_reg << {ea[1:0], 3'b000};

   always_comb begin
      acc_mask     = 4'b1111;
      acc_misalign = 1'b0;
      case (bus.i_id_funct3[1:0])
         2'b00: acc_mask = 4'b0001 << ea[1:0];
         2'b01: begin
            acc_mask     = 4'b0011 << {ea[1], 1'b0};
            acc_misalign = ea[0];
         end
         default: acc_misalign = |ea[1:0];
      endcase
   end

`ifdef NNRV_MDU_EN
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DIV   = 1'b1;
   localparam logic [4:0] DIV_LAST = 5'd31;

   logic [0:0]      state_reg, state_next;
   logic [4:0]      iter_reg, iter_next;
   logic [XLEN-1:0] quo_reg, quo_next;
   logic [XLEN-1:0] rem_reg, rem_next;
   logic [XLEN-1:0] dvs_reg, dvs_next;
   logic            neg_q_reg, neg_q_next;
   logic            neg_r_reg, neg_r_next;
   logic            is_rem_reg, is_rem_next;
   logic            div_rd_en_reg, div_rd_en_next;
   logic [4:0]      div_rd_reg, div_rd_next;

   logic signed [63:0] mul_a, mul_b, mul_prod;
   logic [XLEN-1:0]    mul_res;
   logic               div_signed, div_by_zero, div_ovf;
   logic [XLEN-1:0]    dvd_mag, dvs_mag;
   logic [XLEN:0]      div_shift, div_trial;
   logic [XLEN-1:0]    quo_step, rem_step, quo_fix, rem_fix;

   // 33x33 signed product, sign-extended to 64 bits so every product bit is kept
   assign mul_a    = {{32{bus.i_id_funct3[1:0] != 2'b11 && bus.i_id_rs1_reg[XLEN-1]}}, bus.i_id_rs1_reg};
   assign mul_b    = {{32{bus.i_id_funct3[1:0] == 2'b01 && bus.i_id_rs2_reg[XLEN-1]}}, bus.i_id_rs2_reg};
   assign mul_prod = mul_a * mul_b;
   assign mul_res  = (bus.i_id_funct3[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

   assign div_signed  = !bus.i_id_funct3[0];
   assign div_by_zero = (bus.i_id_rs2_reg == '0);
   assign div_ovf     = div_signed && (bus.i_id_rs1_reg == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (bus.i_id_rs2_reg == '1);
   assign dvd_mag = (div_signed && bus.i_id_rs1_reg[XLEN-1]) ? -bus.i_id_rs1_reg : bus.i_id_rs1_reg;
   assign dvs_mag = (div_signed && bus.i_id_rs2_reg[XLEN-1]) ? -bus.i_id_rs2_reg : bus.i_id_rs2_reg;

   // One restoring step: the dividend streams out of quo_reg MSB-first as quotient bits enter
   assign div_shift = {rem_reg, quo_reg[XLEN-1]};
   assign div_trial = div_shift - {1'b0, dvs_reg};
   assign quo_step  = {quo_reg[XLEN-2:0], !div_trial[XLEN]};
   assign rem_step  = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
   assign quo_fix   = neg_q_reg ? -quo_step : quo_step;
   assign rem_fix   = neg_r_reg ? -rem_step : rem_step;

   assign issue          = bus.i_id_valid && (state_reg == ST_IDLE);
   assign bus.o_id_stall = (state_reg == ST_DIV);
`else
   assign issue          = bus.i_id_valid;
   assign bus.o_id_stall = 1'b0;
`endif

   // ------------------------------------------------------------------ next-state
   always_comb begin
      mem_rd_en_next = 1'b0;
      mem_rd_next    = '0;
      rd_val_next    = '0;
      ram_rd_en_next = 1'b0;
      ram_wr_en_next = 1'b0;
      ram_addr_next  = '0;
      ram_data_next  = '0;
      ram_mask_next  = '0;
      sign_next      = 1'b0;
      misalign_next  = 1'b0;
      rd_ready_next  = 1'b0;
`ifdef NNRV_MDU_EN
      state_next     = state_reg;
      iter_next      = iter_reg;
      quo_next       = quo_reg;
      rem_next       = rem_reg;
      dvs_next       = dvs_reg;
      neg_q_next     = neg_q_reg;
      neg_r_next     = neg_r_reg;
      is_rem_next    = is_rem_reg;
      div_rd_en_next = div_rd_en_reg;
      div_rd_next    = div_rd_reg;
`endif
      if (issue) begin
         mem_rd_next    = bus.i_id_rd;
         mem_rd_en_next = bus.i_id_rd_en;
         rd_ready_next  = 1'b1;
         case (bus.i_id_op)
            OP_ALU_R, OP_ALU_I: rd_val_next = alu_res;
            OP_LOAD, OP_STORE: begin
               ram_addr_next = {ea[XLEN-1:2], 2'b00};
               ram_mask_next = acc_mask;
               misalign_next = acc_misalign;
               if (bus.i_id_op == OP_LOAD) begin
                  ram_rd_en_next = !acc_misalign;
                  sign_next      = !bus.i_id_funct3[2];
                  rd_ready_next  = 1'b0;
                  mem_rd_en_next = bus.i_id_rd_en && !acc_misalign;
               end else begin
                  ram_wr_en_next = !acc_misalign;
                  ram_data_next  = st_data;
                  mem_rd_en_next = 1'b0;
               end
            end
            OP_LUI:   rd_val_next = bus.i_id_imm;
            OP_AUIPC: rd_val_next = bus.i_id_pc + bus.i_id_imm;
            OP_MULDIV: begin
`ifdef NNRV_MDU_EN
               if (!bus.i_id_funct3[2]) begin
                  rd_val_next = mul_res;
               end else if (div_by_zero || div_ovf) begin
                  if (bus.i_id_funct3[1])
                     rd_val_next = div_by_zero ? bus.i_id_rs1_reg : '0;
                  else
                     rd_val_next = div_by_zero ? '1 : bus.i_id_rs1_reg;
               end else begin
                  state_next     = ST_DIV;
                  iter_next      = '0;
                  quo_next       = dvd_mag;
                  rem_next       = '0;
                  dvs_next       = dvs_mag;
                  neg_q_next     = div_signed && (bus.i_id_rs1_reg[XLEN-1] ^ bus.i_id_rs2_reg[XLEN-1]);
                  neg_r_next     = div_signed && bus.i_id_rs1_reg[XLEN-1];
                  is_rem_next    = bus.i_id_funct3[1];
                  div_rd_en_next = bus.i_id_rd_en;
                  div_rd_next    = bus.i_id_rd;
                  mem_rd_en_next = 1'b0;
                  mem_rd_next    = '0;
                  rd_ready_next  = 1'b0;
               end
`else
               mem_rd_en_next = 1'b0;
`endif
            end
            default: mem_rd_en_next = 1'b0;
         endcase
      end
`ifdef NNRV_MDU_EN
      // The 32nd step and the sign fix-up share the completion edge
      if (state_reg == ST_DIV) begin
         quo_next = quo_step;
         rem_next = rem_step;
         if (iter_reg == DIV_LAST) begin
            state_next     = ST_IDLE;
            iter_next      = '0;
            mem_rd_en_next = div_rd_en_reg;
            mem_rd_next    = div_rd_reg;
            rd_val_next    = is_rem_reg ? rem_fix : quo_fix;
            rd_ready_next  = 1'b1;
         end else begin
            iter_next = iter_reg + 5'd1;
         end
      end
`endif
      if (mem_rd_next == 5'd0)
         mem_rd_en_next = 1'b0;
   end

   // ------------------------------------------------------------------ registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem_rd_en_reg <= 1'b0;
         mem_rd_reg    <= '0;
         rd_val_reg    <= '0;
         ram_rd_en_reg <= 1'b0;
         ram_wr_en_reg <= 1'b0;
         ram_addr_reg  <= '0;
         ram_data_reg  <= '0;
         ram_mask_reg  <= '0;
         sign_reg      <= 1'b0;
         misalign_reg  <= 1'b0;
         rd_ready_reg  <= 1'b0;
      end else begin
         mem_rd_en_reg <= mem_rd_en_next;
         mem_rd_reg    <= mem_rd_next;
         rd_val_reg    <= rd_val_next;
         ram_rd_en_reg <= ram_rd_en_next;
         ram_wr_en_reg <= ram_wr_en_next;
         ram_addr_reg  <= ram_addr_next;
         ram_data_reg  <= ram_data_next;
         ram_mask_reg  <= ram_mask_next;
         sign_reg      <= sign_next;
         misalign_reg  <= misalign_next;
         rd_ready_reg  <= rd_ready_next;
      end
   end

`ifdef NNRV_MDU_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= ST_IDLE;
         iter_reg      <= '0;
         quo_reg       <= '0;
         rem_reg       <= '0;
         dvs_reg       <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         is_rem_reg    <= 1'b0;
         div_rd_en_reg <= 1'b0;
         div_rd_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         iter_reg      <= iter_next;
         quo_reg       <= quo_next;
         rem_reg       <= rem_next;
         dvs_reg       <= dvs_next;
         neg_q_reg     <= neg_q_next;
         neg_r_reg     <= neg_r_next;
         is_rem_reg    <= is_rem_next;
         div_rd_en_reg <= div_rd_en_next;
         div_rd_reg    <= div_rd_next;
      end
   end
`endif

   assign bus.o_mem_rd_en     = mem_rd_en_reg;
   assign bus.o_mem_rd        = mem_rd_reg;
   assign bus.o_mem_rd_reg    = rd_val_reg;
   assign bus.o_id_rd_en      = mem_rd_en_reg;
   assign bus.o_id_rd         = mem_rd_reg;
   assign bus.o_id_rd_reg     = rd_val_reg;
   assign bus.o_id_rd_ready   = rd_ready_reg;
   assign bus.o_mem_ram_rd_en = ram_rd_en_reg;
   assign bus.o_mem_ram_wr_en = ram_wr_en_reg;
   assign bus.o_mem_ram_addr  = ram_addr_reg;
   assign bus.o_mem_ram_data  = ram_data_reg;
   assign bus.o_mem_ram_mask  = ram_mask_reg;
   assign bus.o_mem_sign      = sign_reg;
   assign bus.o_misalign      = misalign_reg;

endmodule

// File: tb/tb_nnrv_exec.sv
// Self-checking bench for nnrv_exec: directed cases plus randomized instructions
// compared against a behavioural model of the RV32IM execute rules.
module tb_nnrv_exec;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   cur_idx;

   nnrv_exec_if #(.XLEN(32)) bus_if ();

   nnrv_exec #(.XLEN(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd_en;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        ram_rd;
      logic        ram_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        sign;
      logic        mis;
      logic        ready;
      bit          is_load;
      bit          is_store;
      int          stall;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s (instr %0d) observed=%h expected=%h", tag, cur_idx, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit sub_sra,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int unsigned sh;
      sh = b % 32;
      case (f3)
         3'd0: r = sub_sra ? a - b : a + b;
         3'd1: r = a << sh;
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: r = sub_sra ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic exp_t model(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic rde, input logic [4:0] rd);
      exp_t        e;
      bit          writes;
      logic [31:0] ea;
      int          bytes;
      int          lane;
      longint      p;
      logic [63:0] pu;
      e = '{default: '0};
      e.rd    = rd;
      e.ready = 1'b1;
      writes  = rde;
      case (op)
         3'd0: writes = 1'b0;
         3'd1: e.res = alu_ref(f3, f7 == 1'b1 && (f3 == 3'd0 || f3 == 3'd5), a, b);
         3'd2: e.res = alu_ref(f3, f7 == 1'b1 && f3 == 3'd5, a, imm);
         3'd3, 3'd4: begin
            ea    = a + imm;
            bytes = 1 << (f3 % 4);
            lane  = ea % 4;
            e.mis  = (ea % bytes) != 0;
            e.addr = ea - 32'(lane);
            e.mask = 4'(((1 << bytes) - 1) << lane);
            if (op == 3'd3) begin
               e.is_load = 1'b1;
               e.ram_rd  = !e.mis;
               e.sign    = (f3 < 3'd4);
               e.ready   = 1'b0;
               writes    = rde && !e.mis;
            end else begin
               e.is_store = 1'b1;
               e.ram_wr   = !e.mis;
               e.data     = b << (8 * lane);
               writes     = 1'b0;
            end
         end
         3'd5: e.res = imm;
         3'd6: e.res = pc + imm;
         default: begin
`ifdef NNRV_MDU_EN
            case (f3)
               3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); e.res = p[31:0]; end
               3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); e.res = p[63:32]; end
               3'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); e.res = p[63:32]; end
               3'd3: begin pu = {32'b0, a} * {32'b0, b}; e.res = pu[63:32]; end
               3'd4, 3'd6: begin
                  if (b == 32'd0)
                     e.res = (f3 == 3'd4) ? 32'hFFFF_FFFF : a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                     e.res = (f3 == 3'd4) ? 32'h8000_0000 : 32'd0;
                  else begin
                     e.res   = (f3 == 3'd4) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
                     e.stall = 32;
                  end
               end
               default: begin
                  if (b == 32'd0)
                     e.res = (f3 == 3'd5) ? 32'hFFFF_FFFF : a;
                  else begin
                     e.res   = (f3 == 3'd5) ? a / b : a % b;
                     e.stall = 32;
                  end
               end
            endcase
`else
            writes = 1'b0;
`endif
         end
      endcase
      e.rd_en = writes && (rd != 5'd0);
      return e;
   endfunction

   task automatic check_out(input exp_t e);
      chk("mem_rd_en", bus_if.o_mem_rd_en, e.rd_en);
      chk("id_rd_en", bus_if.o_id_rd_en, e.rd_en);
      if (e.rd_en) begin
         chk("mem_rd", bus_if.o_mem_rd, e.rd);
         chk("mem_rd_reg", bus_if.o_mem_rd_reg, e.res);
         chk("id_rd", bus_if.o_id_rd, e.rd);
         chk("id_rd_reg", bus_if.o_id_rd_reg, e.res);
      end
      chk("rd_ready", bus_if.o_id_rd_ready, e.ready);
      chk("ram_rd_en", bus_if.o_mem_ram_rd_en, e.ram_rd);
      chk("ram_wr_en", bus_if.o_mem_ram_wr_en, e.ram_wr);
      chk("misalign", bus_if.o_misalign, e.mis);
      chk("stall_after", bus_if.o_id_stall, 1'b0);
      if (e.is_load || e.is_store) begin
         chk("ram_addr", bus_if.o_mem_ram_addr, e.addr);
         if (!e.mis) chk("ram_mask", bus_if.o_mem_ram_mask, e.mask);
         if (e.is_store && !e.mis) chk("ram_data", bus_if.o_mem_ram_data, e.data);
         if (e.is_load) chk("mem_sign", bus_if.o_mem_sign, e.sign);
      end
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                            input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic rde, input logic [4:0] rd,
                            input bit drop_valid);
      exp_t e;
      int   stall_cnt;
      int   early_wr;
      cur_idx++;
      e = model(op, f3, f7, pc, a, b, imm, rde, rd);
      bus_if.i_id_valid    = 1'b1;
      bus_if.i_id_op       = op;
      bus_if.i_id_funct3   = f3;
      bus_if.i_id_funct7_5 = f7;
      bus_if.i_id_pc       = pc;
      bus_if.i_id_rs1_reg  = a;
      bus_if.i_id_rs2_reg  = b;
      bus_if.i_id_imm      = imm;
      bus_if.i_id_rd_en    = rde;
      bus_if.i_id_rd       = rd;
      @(posedge clk); #1;
      if (e.stall > 0) begin
         chk("div_bubble_rd_en", bus_if.o_mem_rd_en, 1'b0);
         chk("div_bubble_ready", bus_if.o_id_rd_ready, 1'b0);
         stall_cnt = (bus_if.o_id_stall === 1'b1) ? 1 : 0;
         early_wr  = 0;
         for (int i = 1; i < 32; i++) begin
            bus_if.i_id_valid = (drop_valid && i >= 5 && i <= 8) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (bus_if.o_id_stall === 1'b1) stall_cnt++;
            if (bus_if.o_mem_rd_en !== 1'b0 || bus_if.o_id_rd_ready !== 1'b0) early_wr++;
         end
         bus_if.i_id_valid = 1'b1;
         @(posedge clk); #1;
         chk("stall_cycles", 32'(stall_cnt), 32'd32);
         chk("div_bubble_outputs", 32'(early_wr), 32'd0);
      end
      bus_if.i_id_valid = 1'b0;
      check_out(e);
   endtask

   task automatic bubble();
      bus_if.i_id_valid = 1'b0;
      @(posedge clk); #1;
      chk("bubble_rd_en", bus_if.o_mem_rd_en, 1'b0);
      chk("bubble_ram_rd", bus_if.o_mem_ram_rd_en, 1'b0);
      chk("bubble_ram_wr", bus_if.o_mem_ram_wr_en, 1'b0);
      chk("bubble_misalign", bus_if.o_misalign, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"}, bus_if.o_mem_rd_en, 1'b0);
      chk({tag, "_rd"}, bus_if.o_mem_rd, 5'd0);
      chk({tag, "_rd_reg"}, bus_if.o_mem_rd_reg, 32'd0);
      chk({tag, "_id_rd_en"}, bus_if.o_id_rd_en, 1'b0);
      chk({tag, "_id_rd_reg"}, bus_if.o_id_rd_reg, 32'd0);
      chk({tag, "_ready"}, bus_if.o_id_rd_ready, 1'b0);
      chk({tag, "_ram_rd"}, bus_if.o_mem_ram_rd_en, 1'b0);
      chk({tag, "_ram_wr"}, bus_if.o_mem_ram_wr_en, 1'b0);
      chk({tag, "_addr"}, bus_if.o_mem_ram_addr, 32'd0);
      chk({tag, "_data"}, bus_if.o_mem_ram_data, 32'd0);
      chk({tag, "_mask"}, bus_if.o_mem_ram_mask, 4'd0);
      chk({tag, "_sign"}, bus_if.o_mem_sign, 1'b0);
      chk({tag, "_misalign"}, bus_if.o_misalign, 1'b0);
      chk({tag, "_stall"}, bus_if.o_id_stall, 1'b0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [2:0]  op, f3;
      logic        f7, rde;
      logic [31:0] a, b, imm, pc;
      logic [4:0]  rd;
      logic [2:0]  load_f3 [5];
      int          late_wr;

      load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      checks   = 0;
      failures = 0;
      cur_idx  = 0;
      rst_n    = 1'b0;
      bus_if.i_id_valid    = 1'b0;
      bus_if.i_id_op       = 3'd0;
      bus_if.i_id_funct3   = 3'd0;
      bus_if.i_id_funct7_5 = 1'b0;
      bus_if.i_id_pc       = 32'd0;
      bus_if.i_id_rs1_reg  = 32'd0;
      bus_if.i_id_rs2_reg  = 32'd0;
      bus_if.i_id_imm      = 32'd0;
      bus_if.i_id_rd_en    = 1'b0;
      bus_if.i_id_rd       = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // ADD 5+7 -> x3
      run_instr(3'd1, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0);
      chk("add_rd_reg", bus_if.o_mem_rd_reg, 32'd12);
      chk("add_rd", bus_if.o_mem_rd, 5'd3);
      chk("add_ready", bus_if.o_id_rd_ready, 1'b1);

      // SB 0xAB to 0x103
      run_instr(3'd4, 3'd0, 1'b0, 32'h0, 32'h100, 32'hAB, 32'd3, 1'b0, 5'd0, 1'b0);
      chk("sb_addr", bus_if.o_mem_ram_addr, 32'h100);
      chk("sb_mask", bus_if.o_mem_ram_mask, 4'b1000);
      chk("sb_data", bus_if.o_mem_ram_data, 32'hAB00_0000);

      // LH misaligned, then aligned; misalign must be a one-cycle pulse
      run_instr(3'd3, 3'd1, 1'b0, 32'h0, 32'h100, 32'h0, 32'd1, 1'b1, 5'd4, 1'b0);
      chk("lh_mis_pulse", bus_if.o_misalign, 1'b1);
      chk("lh_mis_rd_en", bus_if.o_mem_rd_en, 1'b0);
      bubble();
      run_instr(3'd3, 3'd1, 1'b0, 32'h0, 32'h100, 32'h0, 32'd2, 1'b1, 5'd4, 1'b0);
      chk("lh_mask", bus_if.o_mem_ram_mask, 4'b1100);
      chk("lh_sign", bus_if.o_mem_sign, 1'b1);
      chk("lh_ready", bus_if.o_id_rd_ready, 1'b0);

      // Divides: -7/2 with valid dropped mid-stall, REM, special cases
      run_instr(3'd7, 3'd4, 1'b0, 32'h0, -32'sd7, 32'd2, 32'd0, 1'b1, 5'd5, 1'b1);
`ifdef NNRV_MDU_EN
      chk("div_m7_2", bus_if.o_mem_rd_reg, 32'hFFFF_FFFD);
`endif
      run_instr(3'd7, 3'd6, 1'b0, 32'h0, -32'sd7, 32'd2, 32'd0, 1'b1, 5'd5, 1'b0);
`ifdef NNRV_MDU_EN
      chk("rem_m7_2", bus_if.o_mem_rd_reg, 32'hFFFF_FFFF);
`endif
      run_instr(3'd7, 3'd5, 1'b0, 32'h0, 32'd1234, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0);
      run_instr(3'd7, 3'd4, 1'b0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd6, 1'b0);
`ifdef NNRV_MDU_EN
      chk("div_ovf", bus_if.o_mem_rd_reg, 32'h8000_0000);
`endif

      // Reset during a divide: no result may appear afterwards
      bus_if.i_id_valid    = 1'b1;
      bus_if.i_id_op       = 3'd7;
      bus_if.i_id_funct3   = 3'd5;
      bus_if.i_id_rs1_reg  = 32'd1000;
      bus_if.i_id_rs2_reg  = 32'd7;
      bus_if.i_id_rd_en    = 1'b1;
      bus_if.i_id_rd       = 5'd9;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus_if.i_id_valid = 1'b0;
      #1;
      check_all_zero("rst_mid_div");
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(3'd1, 3'd0, 1'b0, 32'h0, 32'd1, 32'd1, 32'd0, 1'b1, 5'd2, 1'b0);
      chk("post_rst_add", bus_if.o_mem_rd_reg, 32'd2);
      late_wr = 0;
      bus_if.i_id_valid = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus_if.o_mem_rd_en !== 1'b0 || bus_if.o_id_stall !== 1'b0) late_wr++;
      end
      chk("no_result_after_abort", 32'(late_wr), 32'd0);

      // Randomized instruction stream
      for (int n = 0; n < 250; n++) begin
         op  = 3'($urandom_range(0, 7));
         f3  = 3'($urandom_range(0, 7));
         f7  = 1'($urandom_range(0, 1));
         pc  = 32'($urandom) & 32'hFFFF_FFFC;
         a   = rnd_operand();
         b   = rnd_operand();
         imm = rnd_operand();
         rd  = 5'($urandom_range(0, 31));
         rde = 1'($urandom_range(0, 1));
         if (op == 3'd3) f3 = load_f3[$urandom_range(0, 4)];
         if (op == 3'd4) begin
            f3  = 3'($urandom_range(0, 2));
            rde = 1'b0;
         end
         if (op == 3'd3 || op == 3'd4) imm = 32'($signed(12'($urandom)));
         run_instr(op, f3, f7, pc, a, b, imm, rde, rd, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) bubble();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
